// File: rtl/wb_spi_regs_pkg.sv
// wb_spi_pkg: shared constants for the Wishbone SPI register block.
// Register map indices, CTRL bit positions and data widths.
package wb_spi_pkg;

    localparam int CTRL_W  = 14;
    localparam int RXTX_W  = 128;

    localparam logic [2:0] REG_RX0      = 3'd0;
    localparam logic [2:0] REG_RX1      = 3'd1;
    localparam logic [2:0] REG_RX2      = 3'd2;
    localparam logic [2:0] REG_RX3      = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_DIVIDER  = 3'd5;
    localparam logic [2:0] REG_SS       = 3'd6;
    localparam logic [2:0] REG_UNMAPPED = 3'd7;

    localparam int CTRL_GO     = 8;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_ASS    = 13;

    // Implemented CTRL bits: CHAR_LEN[6:0] and [13:8]; bit 7 always reads 0.
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 14'h3F7F;
    localparam logic [CTRL_W-1:0] CTRL_GO_MASK = 14'h0100;

endpackage

// File: rtl/wb_spi_regs_if.sv
// Wishbone classic bus bundle for the SPI register block.
// master = bus initiator, slave = wb_spi_regs.
interface wb_spi_regs_if;
    logic [4:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        stb_i;
    logic        cyc_i;
    logic        ack_o;
    logic        err_o;

    modport master (output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
                    input  dat_o, ack_o, err_o);
    modport slave  (input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
                    output dat_o, ack_o, err_o);
endinterface

// File: rtl/wb_spi_regs_bytereg.sv
// wb_spi_bytereg: W-bit register with byte-enable write, write inhibit
// and a per-bit clear that takes priority over the write.
module wb_spi_bytereg #(
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_we,
    input  logic                   i_inhibit,
    input  logic [((W+7)/8)-1:0]   i_sel,
    input  logic [W-1:0]           i_d,
    input  logic [W-1:0]           i_clr,
    output logic [W-1:0]           o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_merge;

    // Per-bit merge of new data where the owning byte lane is enabled.
    for (genvar g = 0; g < W; g++) begin : g_merge
        assign w_merge[g] = i_sel[g/8] ? i_d[g] : r_q[g];
    end

    // Register update: clear mask wins, inhibited writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we && !i_inhibit) begin
            r_q <= w_merge & ~i_clr;
        end else begin
            r_q <= r_q & ~i_clr;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_spi_regs.sv
// wb_spi_regs: Wishbone classic responder and register file for the SPI
// controller. Define WB_SPI_ERR_EN to return wb_err_o for accesses to
// address 7 and for writes with no byte enables.
module wb_spi_regs
    import wb_spi_pkg::*;
#(
    parameter int SS_NB = 8,
    parameter int DIV_W = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_spi_regs_if.slave        wb,
    output logic                wb_int_o,
    output logic                go_o,
    input  logic                done_i,
    input  logic [RXTX_W-1:0]   rx_data_i,
    output logic [RXTX_W-1:0]   tx_data_o,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [DIV_W-1:0]    divider_o,
    output logic [SS_NB-1:0]    ss_o
);

    logic [2:0]          w_idx;
    logic                w_access;
    logic                w_bad;
    logic                w_ok;
    logic                w_wr;
    logic                w_busy;
    logic                w_done;
    logic [31:0]         w_rd;
    logic [CTRL_W-1:0]   w_ctrl;
    logic [CTRL_W-1:0]   w_ctrl_clr;
    logic                w_unused_adr;

    logic                r_ack;
    logic                r_err;
    logic [31:0]         r_dat;
    logic                r_int;
    logic [RXTX_W-1:0]   r_rx;

    assign w_idx        = wb.adr_i[4:2];
    assign w_unused_adr = ^wb.adr_i[1:0];
    assign w_access     = wb.cyc_i & wb.stb_i & ~r_ack & ~r_err;
    assign w_busy       = w_ctrl[CTRL_GO];
    assign w_done       = done_i & w_busy;
    assign w_ok         = w_access & ~w_bad;
    assign w_wr         = w_ok & wb.we_i;
    assign w_ctrl_clr   = w_done ? CTRL_GO_MASK : {CTRL_W{1'b0}};

    // Classify accesses that get an error response instead of an ack.
    always_comb begin
        w_bad = 1'b0;
`ifdef WB_SPI_ERR_EN
        if ((w_idx == REG_UNMAPPED) || (wb.we_i && (wb.sel_i == 4'b0000))) begin
            w_bad = 1'b1;
        end else begin
            w_bad = 1'b0;
        end
`endif
    end

    for (genvar t = 0; t < 4; t++) begin : g_tx
        wb_spi_bytereg #(.W(32)) u_tx (
            .clk       (wb_clk_i),
            .rst_n     (wb_rst_i),
            .i_we      (w_wr & (w_idx == 3'(t))),
            .i_inhibit (w_busy),
            .i_sel     (wb.sel_i),
            .i_d       (wb.dat_i),
            .i_clr     (32'h0000_0000),
            .o_q       (tx_data_o[32*t +: 32])
        );
    end

    wb_spi_bytereg #(.W(CTRL_W)) u_ctrl (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .i_we      (w_wr & (w_idx == REG_CTRL)),
        .i_inhibit (w_busy),
        .i_sel     (wb.sel_i[1:0]),
        .i_d       (wb.dat_i[CTRL_W-1:0] & CTRL_WMASK),
        .i_clr     (w_ctrl_clr),
        .o_q       (w_ctrl)
    );

    wb_spi_bytereg #(.W(DIV_W)) u_div (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .i_we      (w_wr & (w_idx == REG_DIVIDER)),
        .i_inhibit (w_busy),
        .i_sel     (wb.sel_i[((DIV_W+7)/8)-1:0]),
        .i_d       (wb.dat_i[DIV_W-1:0]),
        .i_clr     ({DIV_W{1'b0}}),
        .o_q       (divider_o)
    );

    wb_spi_bytereg #(.W(SS_NB)) u_ss (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_i),
        .i_we      (w_wr & (w_idx == REG_SS)),
        .i_inhibit (w_busy),
        .i_sel     (wb.sel_i[((SS_NB+7)/8)-1:0]),
        .i_d       (wb.dat_i[SS_NB-1:0]),
        .i_clr     ({SS_NB{1'b0}}),
        .o_q       (ss_o)
    );

    // Read data mux; unimplemented bits and the unmapped slot read 0.
    always_comb begin
        w_rd = 32'h0000_0000;
        case (w_idx)
            REG_RX0:     w_rd = r_rx[31:0];
            REG_RX1:     w_rd = r_rx[63:32];
            REG_RX2:     w_rd = r_rx[95:64];
            REG_RX3:     w_rd = r_rx[127:96];
            REG_CTRL:    w_rd = 32'(w_ctrl);
            REG_DIVIDER: w_rd = 32'(divider_o);
            REG_SS:      w_rd = 32'(ss_o);
            default:     w_rd = 32'h0000_0000;
        endcase
    end

    // Bus response, RX capture and interrupt flag (set beats clear).
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'h0000_0000;
            r_int <= 1'b0;
            r_rx  <= {RXTX_W{1'b0}};
        end else begin
            r_ack <= w_ok;
            r_err <= w_access & w_bad;
            if (w_ok) begin
                r_dat <= w_rd;
            end
            if (w_done & w_ctrl[CTRL_IE]) begin
                r_int <= 1'b1;
            end else if (w_ok) begin
                r_int <= 1'b0;
            end
            if (w_done) begin
                r_rx <= rx_data_i;
            end
        end
    end

    assign wb.ack_o = r_ack;
`ifdef WB_SPI_ERR_EN
    assign wb.err_o = r_err;
`else
    assign wb.err_o = 1'b0;
`endif
    assign wb.dat_o = r_dat;
    assign wb_int_o = r_int;
    assign go_o     = w_ctrl[CTRL_GO];
    assign ctrl_o   = w_ctrl;

endmodule
